// File: rtl/if_stage_if.sv
// Instruction-bus interface between the fetch stage and the instruction memory.
//   ibus_req    : fetch request valid (master -> slave)
//   ibus_addr   : fetch byte address (master -> slave)
//   ibus_gnt    : request accepted this cycle (slave -> master)
//   ibus_rvalid : response data valid, held until the master takes it (slave -> master)
//   ibus_rdata  : fetched instruction word (slave -> master)
interface if_stage_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;

    modport master (
        output ibus_req,
        output ibus_addr,
        input  ibus_gnt,
        input  ibus_rvalid,
        input  ibus_rdata
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        output ibus_gnt,
        output ibus_rvalid,
        output ibus_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one outstanding fetch at a time on the
// instruction bus and holds one fetched entry for the decode stage.
// Handles MIPS branch delay slots, flush redirects (discarding an in-flight
// response) and misaligned-PC address errors.
//   clk, rst              : clock, synchronous active-high reset
//   ibus                  : instruction bus (master side)
//   id_valid/pc/inst/adel : held entry presented to ID
//   id_stall              : ID cannot consume this cycle
//   br_en, br_target      : taken branch for the entry ID consumes this cycle
//   flush_en, flush_pc    : exception/ERET redirect, highest priority
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  ibus,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel,
    input  logic        id_stall,
    input  logic        br_en,
    input  logic [31:0] br_target,
    input  logic        flush_en,
    input  logic [31:0] flush_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc_r;
    logic [31:0] addr_r;     // address of the outstanding request
    logic [31:0] tgt_r;
    logic        br_pend;
    logic        drop;

    logic        req_c;
    logic        accept;
    logic        load_rsp;
    logic        load_adel;
    logic        take_rsp;
    logic        consume;
    logic        misal;
    logic        br_take;

    assign consume        = id_valid && !id_stall;
    assign misal          = (pc_r[1:0] != 2'b00);
    assign br_take        = consume && br_en;
    assign ibus.ibus_req  = req_c;
    assign ibus.ibus_addr = pc_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_c     = 1'b0;
        load_rsp  = 1'b0;
        load_adel = 1'b0;
        take_rsp  = 1'b0;
        unique case (state)
            S_REQ: begin
                if (misal) begin
                    // Address error goes straight into the entry, but never over
                    // an unconsumed one.
                    if (!id_valid || consume) begin
                        load_adel = 1'b1;
                        state_nx  = S_HOLD;
                    end
                end else begin
                    req_c = !rst;
                    if (!rst && ibus.ibus_gnt) begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ibus.ibus_rvalid) begin
                    if (drop) begin
                        take_rsp = 1'b1;
                        state_nx = S_REQ;
                    end else if (!id_valid || consume) begin
                        take_rsp = 1'b1;
                        load_rsp = 1'b1;
                        state_nx = id_stall ? S_HOLD : S_REQ;
                    end
                end
            end
            S_HOLD: begin
                // An address-error entry parks the stage until a flush.
                if (consume && !id_adel) begin
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase

        accept = req_c && ibus.ibus_gnt;

        if (flush_en) begin
            load_rsp  = 1'b0;
            load_adel = 1'b0;
            // A response arriving in the flush cycle is taken and discarded here;
            // otherwise a request still in flight must be waited out.
            if ((state == S_WAIT && !ibus.ibus_rvalid) || accept) begin
                state_nx = S_WAIT;
            end else begin
                state_nx = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            addr_r   <= '0;
            tgt_r    <= '0;
            br_pend  <= 1'b0;
            drop     <= 1'b0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
            id_adel  <= 1'b0;
        end else begin
            if (accept) begin
                addr_r <= pc_r;
            end

            if (flush_en) begin
                pc_r    <= flush_pc;
                br_pend <= 1'b0;
            end else begin
                if (accept) begin
                    pc_r    <= br_pend ? tgt_r : pc_r + 32'd4;
                    br_pend <= 1'b0;
                end
                if (br_take) begin
                    if (pc_r == id_pc + 32'd4) begin
                        // Delay slot not yet issued: redirect after it is granted,
                        // or right now if it is being granted this very cycle.
                        if (accept) begin
                            pc_r <= br_target;
                        end else begin
                            tgt_r   <= br_target;
                            br_pend <= 1'b1;
                        end
                    end else if (pc_r == id_pc + 32'd8) begin
                        pc_r <= br_target;
                    end
                end
            end

            if (flush_en) begin
                id_valid <= 1'b0;
                id_adel  <= 1'b0;
            end else if (load_rsp) begin
                id_valid <= 1'b1;
                id_pc    <= addr_r;
                id_inst  <= ibus.ibus_rdata;
                id_adel  <= 1'b0;
            end else if (load_adel) begin
                id_valid <= 1'b1;
                id_pc    <= pc_r;
                id_inst  <= '0;
                id_adel  <= 1'b1;
            end else if (consume) begin
                id_valid <= 1'b0;
            end

            if (flush_en) begin
                drop <= (state_nx == S_WAIT);
            end else if (take_rsp && drop) begin
                drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: drives the instruction bus by hand with
// zero-wait grants/responses and checks requests and the ID entry against
// hand-computed values.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;
    logic        id_stall;
    logic        br_en;
    logic [31:0] br_target;
    logic        flush_en;
    logic [31:0] flush_pc;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'hBFC00000)) dut (
        .clk      (clk),
        .rst      (rst),
        .ibus     (bus),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_adel  (id_adel),
        .id_stall (id_stall),
        .br_en    (br_en),
        .br_target(br_target),
        .flush_en (flush_en),
        .flush_pc (flush_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Called just after a rising edge with the DUT in REQ and no entry held;
    // returns just after a rising edge with the fetched entry consumed.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d);
        bus.ibus_gnt = 1'b1;
        mid();
        check({tag, " req"}, {31'd0, bus.ibus_req}, 32'd1);
        check({tag, " addr"}, bus.ibus_addr, a);
        step();
        bus.ibus_gnt    = 1'b0;
        bus.ibus_rvalid = 1'b1;
        bus.ibus_rdata  = d;
        mid();
        check({tag, " wait req"}, {31'd0, bus.ibus_req}, 32'd0);
        step();
        bus.ibus_rvalid = 1'b0;
        mid();
        check({tag, " valid"}, {31'd0, id_valid}, 32'd1);
        check({tag, " pc"}, id_pc, a);
        check({tag, " inst"}, id_inst, d);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; id_stall = 1'b0; br_en = 1'b0; br_target = '0;
        flush_en = 1'b0; flush_pc = '0;
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b0; bus.ibus_rdata = '0;

        // Reset state
        step(); step();
        mid();
        check("rst req", {31'd0, bus.ibus_req}, 32'd0);
        check("rst valid", {31'd0, id_valid}, 32'd0);
        check("rst pc", id_pc, 32'd0);
        check("rst inst", id_inst, 32'd0);
        check("rst adel", {31'd0, id_adel}, 32'd0);
        step();
        rst = 1'b0;

        // Sequential fetch, zero wait
        fetch("f0", 32'hBFC00000, 32'h1111_0000);
        fetch("f1", 32'hBFC00004, 32'h1111_0004);
        fetch("f2", 32'hBFC00008, 32'h1111_0008);

        // Stall while an entry is held
        id_stall = 1'b1;
        bus.ibus_gnt = 1'b1;
        mid();
        check("st addr", bus.ibus_addr, 32'hBFC0000C);
        step();
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h4444_4444;
        step();
        bus.ibus_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("st req", {31'd0, bus.ibus_req}, 32'd0);
            check("st pc", id_pc, 32'hBFC0000C);
            check("st inst", id_inst, 32'h4444_4444);
            step();
        end
        id_stall = 1'b0;
        mid();
        check("st release req", {31'd0, bus.ibus_req}, 32'd0);
        step();
        mid();
        check("st resume req", {31'd0, bus.ibus_req}, 32'd1);
        check("st resume addr", bus.ibus_addr, 32'hBFC00010);
        check("st resume valid", {31'd0, id_valid}, 32'd0);
        step();

        // Branch at BFC00010, delay slot not yet granted
        id_stall = 1'b1;
        bus.ibus_gnt = 1'b1;
        mid();
        check("b1 addr P", bus.ibus_addr, 32'hBFC00010);
        step();
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h5555_0010;
        step();
        bus.ibus_rvalid = 1'b0;
        id_stall = 1'b0; br_en = 1'b1; br_target = 32'h8000_0000;
        mid();
        check("b1 held pc", id_pc, 32'hBFC00010);
        check("b1 hold req", {31'd0, bus.ibus_req}, 32'd0);
        step();
        br_en = 1'b0;
        bus.ibus_gnt = 1'b1;
        mid();
        check("b1 ds addr", bus.ibus_addr, 32'hBFC00014);
        step();
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h5555_0014;
        step();
        bus.ibus_rvalid = 1'b0;
        mid();
        check("b1 ds pc", id_pc, 32'hBFC00014);
        check("b1 ds inst", id_inst, 32'h5555_0014);
        check("b1 tgt req", {31'd0, bus.ibus_req}, 32'd1);
        check("b1 tgt addr", bus.ibus_addr, 32'h8000_0000);
        step();

        // Branch at BFC00010, delay slot already granted
        flush_en = 1'b1; flush_pc = 32'hBFC00010;
        step();
        flush_en = 1'b0;
        bus.ibus_gnt = 1'b1;
        mid();
        check("b2 addr P", bus.ibus_addr, 32'hBFC00010);
        step();
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h6666_0010;
        step();
        bus.ibus_rvalid = 1'b0;
        id_stall = 1'b1; bus.ibus_gnt = 1'b1;
        mid();
        check("b2 ds addr", bus.ibus_addr, 32'hBFC00014);
        check("b2 held pc", id_pc, 32'hBFC00010);
        step();
        bus.ibus_gnt = 1'b0; id_stall = 1'b0; br_en = 1'b1; br_target = 32'h8000_0000;
        bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h6666_0014;
        mid();
        check("b2 wait req", {31'd0, bus.ibus_req}, 32'd0);
        step();
        br_en = 1'b0; bus.ibus_rvalid = 1'b0;
        mid();
        check("b2 ds pc", id_pc, 32'hBFC00014);
        check("b2 ds inst", id_inst, 32'h6666_0014);
        check("b2 tgt req", {31'd0, bus.ibus_req}, 32'd1);
        check("b2 tgt addr", bus.ibus_addr, 32'h8000_0000);

        // Flush with a request outstanding
        id_stall = 1'b1; bus.ibus_gnt = 1'b1;
        step();
        bus.ibus_gnt = 1'b0; flush_en = 1'b1; flush_pc = 32'h8000_0180;
        mid();
        check("fl held valid", {31'd0, id_valid}, 32'd1);
        step();
        flush_en = 1'b0;
        mid();
        check("fl valid", {31'd0, id_valid}, 32'd0);
        check("fl wait req", {31'd0, bus.ibus_req}, 32'd0);
        bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'hDEAD_BEEF;
        step();
        bus.ibus_rvalid = 1'b0;
        mid();
        check("fl drop valid", {31'd0, id_valid}, 32'd0);
        check("fl drop inst", id_inst, 32'h6666_0014);
        check("fl req", {31'd0, bus.ibus_req}, 32'd1);
        check("fl addr", bus.ibus_addr, 32'h8000_0180);
        id_stall = 1'b0;

        // Misaligned flush target
        flush_en = 1'b1; flush_pc = 32'h8000_0182;
        step();
        flush_en = 1'b0;
        mid();
        check("ae req", {31'd0, bus.ibus_req}, 32'd0);
        step();
        mid();
        check("ae valid", {31'd0, id_valid}, 32'd1);
        check("ae adel", {31'd0, id_adel}, 32'd1);
        check("ae pc", id_pc, 32'h8000_0182);
        check("ae inst", id_inst, 32'd0);
        check("ae hold req", {31'd0, bus.ibus_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            mid();
            check("ae stuck req", {31'd0, bus.ibus_req}, 32'd0);
        end

        // Flush and branch in the same cycle
        flush_en = 1'b1; flush_pc = 32'hBFC00040;
        step();
        flush_en = 1'b0;
        id_stall = 1'b1; bus.ibus_gnt = 1'b1;
        mid();
        check("fb addr P", bus.ibus_addr, 32'hBFC00040);
        step();
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h7777_0040;
        step();
        bus.ibus_rvalid = 1'b0;
        id_stall = 1'b0; br_en = 1'b1; br_target = 32'h8000_0000;
        flush_en = 1'b1; flush_pc = 32'hBFC00100;
        step();
        br_en = 1'b0; flush_en = 1'b0;
        mid();
        check("fb valid", {31'd0, id_valid}, 32'd0);
        check("fb req", {31'd0, bus.ibus_req}, 32'd1);
        check("fb addr", bus.ibus_addr, 32'hBFC00100);
        bus.ibus_gnt = 1'b1;
        step();
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h7777_0100;
        step();
        bus.ibus_rvalid = 1'b0;
        mid();
        check("fb pc", id_pc, 32'hBFC00100);
        check("fb next addr", bus.ibus_addr, 32'hBFC00104);

        // PC wrap
        flush_en = 1'b1; flush_pc = 32'hFFFF_FFFC;
        step();
        flush_en = 1'b0; bus.ibus_gnt = 1'b1;
        mid();
        check("wr addr", bus.ibus_addr, 32'hFFFF_FFFC);
        step();
        bus.ibus_gnt = 1'b0; bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h8888_8888;
        step();
        bus.ibus_rvalid = 1'b0;
        mid();
        check("wr pc", id_pc, 32'hFFFF_FFFC);
        check("wr next addr", bus.ibus_addr, 32'h0000_0000);

        // Reset mid-operation; the bus model is reset too
        bus.ibus_gnt = 1'b1;
        step();
        bus.ibus_gnt = 1'b0; rst = 1'b1;
        step();
        mid();
        check("mr req", {31'd0, bus.ibus_req}, 32'd0);
        check("mr valid", {31'd0, id_valid}, 32'd0);
        check("mr pc", id_pc, 32'd0);
        step();
        rst = 1'b0;
        mid();
        check("mr first req", {31'd0, bus.ibus_req}, 32'd1);
        check("mr first addr", bus.ibus_addr, 32'hBFC00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
